pipelined_adder: RTL
====================

Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the team's fixed 16-bit ripple adder.
- Splits a WIDTH-bit add/subtract into STAGES registered carry segments, giving one result per clock at STAGES cycles latency.
- Has valid/ready flow control and back-pressure, so it drops into the datapath between operand sources and accumulator/ALU stages.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of STAGES
STAGES, 4, number of pipeline segments (>=1); segment width SEG = WIDTH/STAGES

Ports:
clk  input  1  sole clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand beat present
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add mode only)
sub  input  1  0 = A+B+cin, 1 = A-B (cin ignored)
out_valid  output  1  result beat present
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
carry  output  1  carry-out (in sub mode: 1 = no borrow)

Behaviour:
- Interface decision: one clock `clk`; `rst` is asynchronous and active-high.
- Reset: all stage valid bits clear, all data/carry registers 0. Outputs then read out_valid=0, sum=0, carry=0. in_ready=1 in the first cycle after rst deasserts.
- Reset mid-operation: in-flight beats are discarded, never emitted.
- Global advance: adv = !out_valid || out_ready; in_ready = adv (combinational).
  - On adv, every stage shifts forward one position; bubbles shift too.
  - When adv=0 all registers hold.
- Input accept: a beat is accepted when in_valid && in_ready. If adv && !in_valid, a bubble (valid=0) enters stage 0.
- Sub mode: B operand is ~b and carry-in is forced to 1. sub is captured with the beat.
- Stage k (0..STAGES-1): adds slice [k*SEG +: SEG] of A and effective B with the carry registered from stage k-1 (stage 0 uses the effective cin).
  - Stores SEG result bits plus carry-out.
  - Unprocessed upper operand slices travel alongside in skew registers.
  - Completed lower result slices travel alongside in deskew registers.
- Latency: exactly STAGES cycles from accept to out_valid when out_ready stays high. Throughput 1 beat/cycle.
- STAGES=1: single registered full-width add, latency 1.
- Overflow wraps modulo 2^WIDTH; carry reports the bit out of the top segment.
- Ordering: results leave strictly in acceptance order. No beat is dropped or duplicated under any out_ready pattern.
- Simultaneous accept and emit in one cycle is allowed; full throughput is sustained with out_ready=1.
- Illegal parameter set (WIDTH % STAGES != 0 or STAGES < 1) is caught by an elaboration-time check that stops compilation.

Optional Feature:
- Macro: PIPELINED_ADDER_OVF_EN.
- Defined:
  - Extra output port `overflow` (1 bit) = signed two's-complement overflow of the final result (carry into MSB XOR carry out of MSB).
  - Registered with the beat. Reset value 0.
- Undefined: port absent; no MSB-carry tracking logic.

Decomposition:
- Package `adder_pkg`:
  - localparam defaults (ADD_WIDTH_DEF=16, ADD_STAGES_DEF=4)
  - typedef for the op mode (ADD=0, SUB=1)
  - function computing SEG from WIDTH and STAGES
- Sub-module `adder_segment`:
  - One SEG-wide registered slice: inputs slice A/B, carry-in, enable, valid-in.
  - Outputs registered slice sum, carry-out, valid-out.
  - Instantiated STAGES times via generate.

Test Plan:
- Reset/idle: rst=1 for 3 cycles then 0, no in_valid -> out_valid=0, sum=0, carry=0; in_ready=1 after deassert.
- Basic add, defaults: a=16'h00FF, b=16'h0001, cin=0, out_ready=1 -> after exactly 4 cycles out_valid=1, sum=16'h0100, carry=0.
- Full-width carry ripple through all segments: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, carry=1. Same with sub=1, a=16'h0005, b=16'h0007 -> sum=16'hFFFE, carry=0.
- Back-pressure: stream 8 beats a=i, b=i (i=1..8) with out_ready toggling 1,0,0,1,… -> sums 2,4,…,16 in order; in_ready low exactly while out_valid && !out_ready.
- Reset mid-flight: accept 3 beats, assert rst on cycle 2 -> no result emitted; next beat a=3, b=4 returns 7 with latency 4.
- Parameter sweep: WIDTH=32/STAGES=1 and WIDTH=32/STAGES=8, 1000 random beats vs reference model. With PIPELINED_ADDER_OVF_EN: a=16'h7FFF, b=16'h0001 -> overflow=1, sum=16'h8000.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// adder_pkg: shared definitions for the pipelined adder slice.
//   ADD_WIDTH_DEF / ADD_STAGES_DEF : default operand width and segment count
//   op_mode_e                      : operation select (ADD = 0, SUB = 1)
//   seg_width()                    : per-segment width derived from WIDTH/STAGES
package adder_pkg;

    localparam int unsigned ADD_WIDTH_DEF  = 16;
    localparam int unsigned ADD_STAGES_DEF = 4;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } op_mode_e;

    // Guarded against STAGES = 0 so an illegal set reaches the top-level
    // parameter check instead of failing on a division first.
    function automatic int unsigned seg_width(input int unsigned width,
                                              input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

endpackage

// File: rtl/pipelined_adder_segment.sv
// adder_segment: one SEG-bit registered slice of the pipelined adder.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   en        : global advance; all registers hold while low
//   vin       : beat-valid travelling with this slice
//   a, b, cin : slice operands (b already inverted for subtract) and carry-in
//   sum, cout : registered slice result and carry-out
//   vout      : registered beat-valid
module adder_segment #(
    parameter int unsigned SEG = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           vin,
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           vout
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
            vout <= 1'b0;
        end else if (en) begin
            {cout, sum} <= {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
            vout        <= vin;
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into STAGES registered carry
// segments; one result per clock, STAGES cycles latency, valid/ready flow
// control with back-pressure (all stages advance together).
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake
//   a, b, cin, sub       : operands, carry-in (add only), 1 = A-B
//   out_valid / out_ready: result handshake
//   sum, carry           : result and carry-out (sub: 1 = no borrow)
//   overflow             : signed overflow, only with PIPELINED_ADDER_OVF_EN
// Optional feature macro: PIPELINED_ADDER_OVF_EN
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = ADD_WIDTH_DEF,
    parameter int unsigned STAGES = ADD_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned SEG = seg_width(WIDTH, STAGES);

    if ((STAGES < 1) || ((WIDTH % ((STAGES < 1) ? 1 : STAGES)) != 0)) begin : g_param_check
        $fatal(1, "pipelined_adder: STAGES must be >= 1 and divide WIDTH");
    end

    op_mode_e          mode;
    logic [WIDTH-1:0]  b_eff;
    logic              c_eff;
    logic              adv;
    logic [WIDTH-1:0]  op_a    [STAGES];
    logic [WIDTH-1:0]  op_b    [STAGES];
    logic [SEG-1:0]    seg_sum [STAGES];
    logic [STAGES-1:0] seg_cin;
    logic [STAGES-1:0] seg_cout;
    logic [STAGES-1:0] seg_vin;
    logic [STAGES-1:0] seg_vout;

    assign mode      = op_mode_e'(sub);
    assign b_eff     = (mode == SUB) ? ~b : b;
    assign c_eff     = (mode == SUB) ? 1'b1 : cin;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = seg_vout[STAGES-1];
    assign carry     = seg_cout[STAGES-1];

    always_comb begin
        seg_cin    = '0;
        seg_vin    = '0;
        seg_cin[0] = c_eff;
        seg_vin[0] = in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            seg_cin[k] = seg_cout[k-1];
            seg_vin[k] = seg_vout[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        adder_segment #(.SEG(SEG)) u_seg (
            .clk  (clk),
            .rst  (rst),
            .en   (adv),
            .vin  (seg_vin[k]),
            .a    (op_a[k][k*SEG +: SEG]),
            .b    (op_b[k][k*SEG +: SEG]),
            .cin  (seg_cin[k]),
            .sum  (seg_sum[k]),
            .cout (seg_cout[k]),
            .vout (seg_vout[k])
        );
    end

    if (STAGES > 1) begin : g_skew
        // Entry j travels alongside segment j+1: a_sk/b_sk carry the operand
        // slices still to be added, lo collects finished slices 0..j.
        logic [WIDTH-1:0] a_sk [STAGES-1];
        logic [WIDTH-1:0] b_sk [STAGES-1];
        logic [WIDTH-1:0] lo   [STAGES-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int unsigned j = 0; j < STAGES-1; j++) begin
                    a_sk[j] <= '0;
                    b_sk[j] <= '0;
                    lo[j]   <= '0;
                end
            end else if (adv) begin
                a_sk[0] <= a;
                b_sk[0] <= b_eff;
                lo[0]   <= WIDTH'(seg_sum[0]);
                for (int unsigned j = 1; j < STAGES-1; j++) begin
                    a_sk[j] <= a_sk[j-1];
                    b_sk[j] <= b_sk[j-1];
                    // upper bits of lo[j-1] are always zero, so OR merges the slice
                    lo[j]   <= lo[j-1] | (WIDTH'(seg_sum[j]) << (j*SEG));
                end
            end
        end

        always_comb begin
            op_a[0] = a;
            op_b[0] = b_eff;
            for (int unsigned j = 1; j < STAGES; j++) begin
                op_a[j] = a_sk[j-1];
                op_b[j] = b_sk[j-1];
            end
        end

        assign sum = lo[STAGES-2] | (WIDTH'(seg_sum[STAGES-1]) << ((STAGES-1)*SEG));
    end else begin : g_noskew
        always_comb begin
            op_a[0] = a;
            op_b[0] = b_eff;
        end

        assign sum = seg_sum[0];
    end

`ifdef PIPELINED_ADDER_OVF_EN
    // Carry into the MSB equals sum_msb ^ a_msb ^ b_msb, so only the operand
    // MSB parity has to be registered alongside the top segment.
    logic msb_x;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msb_x <= 1'b0;
        end else if (adv) begin
            msb_x <= op_a[STAGES-1][WIDTH-1] ^ op_b[STAGES-1][WIDTH-1];
        end
    end

    assign overflow = msb_x ^ sum[WIDTH-1] ^ carry;
`endif

endmodule
